ram_responder: RTL

- Bus-side RAM device that answers the motherboard's ctrl/stat handshake.
- Watches the write and read request pins on its ctrl input and latches addr and write data.
- Performs the access after a fixed latency, raises ACK, and holds it until the request pins drop (four-phase handshake).
- Drives read data onto the shared data bus that returns to the motherboard.

---
 rtl/ram_if.sv | 19 +
 rtl/ram_responder.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/ram_if.sv
// ram_if: motherboard <-> RAM ctrl/stat bus bundle.
// master = motherboard side, slave = RAM device side.
interface ram_if;
  logic [31:0] ram_ctrl;
  logic [31:0] ram_stat;
  logic [31:0] addr;
  logic [31:0] data_in;
  logic [31:0] data_out;

  modport master (
    output ram_ctrl, addr, data_in,
    input  ram_stat, data_out
  );

  modport slave (
    input  ram_ctrl, addr, data_in,
    output ram_stat, data_out
  );
endinterface

// File: rtl/ram_responder.sv
// ram_responder: RAM device on a four-phase ctrl/stat handshake.
// Option RAM_INIT_ZERO_EN: zero-fill sweep (CLEAR) after reset.
`ifndef RAM_WRITE_PIN
`define RAM_WRITE_PIN 0
`endif
`ifndef RAM_READ_PIN
`define RAM_READ_PIN 1
`endif
`ifndef RAM_ACK
`define RAM_ACK 0
`endif

module ram_responder #(
  parameter int ADDR_BITS = 11,
  parameter int LATENCY   = 2,
  parameter int BUSY_BIT  = 1
) (
  input  logic clk,
  input  logic rst,
  ram_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_BITS;
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_ACK    = 2'd2;
  localparam logic [1:0] S_CLEAR  = 2'd3;
`ifdef RAM_INIT_ZERO_EN
  localparam logic [1:0] S_RST = S_CLEAR;
`else
  localparam logic [1:0] S_RST = S_IDLE;
`endif

  logic [31:0] mem [DEPTH];

  logic [1:0]           state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 wr_q, wr_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [31:0]          wdata_q, wdata_d;
  logic                 ack_q, ack_d;
  logic [31:0]          dout_q, dout_d;
`ifdef RAM_INIT_ZERO_EN
  logic [ADDR_BITS-1:0] clr_q, clr_d;
`endif

  logic                 we;
  logic [ADDR_BITS-1:0] we_addr;
  logic [31:0]          we_data;
  logic                 req_wr, req_rd;
  logic [31:0]          stat;
  logic                 unused_bits;

  assign req_wr = bus.ram_ctrl[`RAM_WRITE_PIN];
  assign req_rd = bus.ram_ctrl[`RAM_READ_PIN];
  assign unused_bits = ^{bus.ram_ctrl, bus.addr};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ack_d   = ack_q;
    dout_d  = dout_q;
    we      = 1'b0;
    we_addr = addr_q;
    we_data = wdata_q;
`ifdef RAM_INIT_ZERO_EN
    clr_d   = clr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_wr || req_rd) begin
          wr_d    = req_wr;
          addr_d  = bus.addr[ADDR_BITS-1:0];
          wdata_d = bus.data_in;
          cnt_d   = 4'(LATENCY);
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (cnt_q == 4'd0) begin
          if (wr_q) we = 1'b1;
          else      dout_d = mem[addr_q];
          ack_d   = 1'b1;
          state_d = S_ACK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ACK: begin
        if (!req_wr && !req_rd) begin
          ack_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
`ifdef RAM_INIT_ZERO_EN
      S_CLEAR: begin
        we      = 1'b1;
        we_addr = clr_q;
        we_data = 32'd0;
        if (clr_q == ADDR_BITS'(DEPTH - 1))
          state_d = S_IDLE;
        else
          clr_d = clr_q + 1'b1;
      end
`endif
      default: begin
        ack_d   = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_RST;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      ack_q   <= 1'b0;
      dout_q  <= 32'd0;
`ifdef RAM_INIT_ZERO_EN
      clr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ack_q   <= ack_d;
      dout_q  <= dout_d;
`ifdef RAM_INIT_ZERO_EN
      clr_q   <= clr_d;
`endif
    end
  end

  // Storage has no reset; contents survive rst unless swept.
  always_ff @(posedge clk) begin
    if (we) mem[we_addr] <= we_data;
  end

  always_comb begin
    stat = 32'd0;
    stat[`RAM_ACK] = ack_q;
`ifdef RAM_INIT_ZERO_EN
    stat[BUSY_BIT] = (state_q == S_CLEAR);
`endif
  end

  assign bus.ram_stat = stat;
  assign bus.data_out = dout_q;
endmodule
